series_adder_seq: RTL

//  Job controller for the bit-serial column adder. Holds M operand words of N bits written by the CPU.
//  On start, transposes them into N bit-slices and streams the slices LSB-first to the adder.

---
 rtl/series_adder_pkg.sv | 26 ++
 rtl/series_adder_seq_mux.sv | 27 ++
 rtl/series_adder_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/series_adder_pkg.sv
// ----------------------------------------------------------------------------
// series_adder_pkg
// Shared types and constants for the bit-serial column adder job controller.
//   seq_state_t : controller FSM states (IDLE -> ISSUE -> WAIT -> IDLE)
//   IDX_W/SUM_W : operand-index and sum widths for the default build
//                 (M_DEF operands of N_DEF bits)
//   ERR_BUSY    : err bit for a write/start rejected while a job runs
//   ERR_TO      : err bit for a watchdog timeout (SEQ_TIMEOUT_EN builds only)
// ----------------------------------------------------------------------------
package series_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } seq_state_t;

  localparam int M_DEF = 32;
  localparam int N_DEF = 8;
  localparam int IDX_W = $clog2(M_DEF);
  localparam int SUM_W = $clog2(M_DEF) + N_DEF;

  localparam int ERR_BUSY = 0;
  localparam int ERR_TO   = 1;

endpackage

// File: rtl/series_adder_seq_mux.sv
// ----------------------------------------------------------------------------
// bitslice_mux
// Combinational M x N transpose: picks bit `col` of every operand word and
// packs them into one M-bit slice (slice[i] = operand[i][col]).
// Ports:
//   ops   in  M*N   operand words, operand i occupies ops[i*N +: N]
//   col   in  clog2(N) selected bit column
//   slice out M     selected column across all operands
// ----------------------------------------------------------------------------
module bitslice_mux #(
  parameter int M = 32,
  parameter int N = 8
) (
  input  logic [M*N-1:0]       ops,
  input  logic [$clog2(N)-1:0] col,
  output logic [M-1:0]         slice
);

  // Gather bit `col` from each operand word.
  always_comb begin
    slice = {M{1'b0}};
    for (int i = 0; i < M; i++) begin
      slice[i] = ops[i*N + int'(col)];
    end
  end

endmodule

// File: rtl/series_adder_seq.sv
// ----------------------------------------------------------------------------
// series_adder_seq
// Job controller for the bit-serial column adder. The CPU writes M operand
// words of N bits; on start the words are streamed to the adder as N bit-
// slices, LSB column first, on consecutive cycles. The adder's result is
// captured into sum and held for the CPU.
// Optional feature macro: SEQ_TIMEOUT_EN enables a WAIT watchdog of TO_CYC
// cycles; without it WAIT holds until res_vld or reset and err[1] stays 0.
// Ports:
//   clk, rst_p         clock, synchronous active-high reset
//   wr_en/addr/data    operand write port (ignored and flagged while busy)
//   start              one-cycle job start pulse
//   slice_data/vld     slice stream to the adder
//   res_vld/res        result from the adder
//   busy               job in ISSUE or WAIT
//   done               sticky: sum valid, cleared by start or wr_en
//   sum                captured result
//   err                sticky: [0] rejected write/start, [1] timeout
// ----------------------------------------------------------------------------
module series_adder_seq
  import series_adder_pkg::*;
#(
  parameter int M      = 32,
  parameter int N      = 8,
  parameter int TO_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst_p,
  input  logic                    wr_en,
  input  logic [$clog2(M)-1:0]    wr_addr,
  input  logic [N-1:0]            wr_data,
  input  logic                    start,
  output logic [M-1:0]            slice_data,
  output logic                    slice_vld,
  input  logic                    res_vld,
  input  logic [$clog2(M)+N-1:0]  res,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(M)+N-1:0]  sum,
  output logic [1:0]              err
);

  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  seq_state_t            state;
  logic [M-1:0][N-1:0]   op_mem;
  logic [KW-1:0]         k;

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0]         wd_cnt;
`endif

  // slice_data is a pure function of registered buffer and column index.
  bitslice_mux #(
    .M (M),
    .N (N)
  ) u_mux (
    .ops   (op_mem),
    .col   (k),
    .slice (slice_data)
  );

  // Controller FSM, operand buffer, result capture and watchdog.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      state     <= IDLE;
      op_mem    <= '0;
      k         <= {KW{1'b0}};
      slice_vld <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      err       <= 2'b00;
`ifdef SEQ_TIMEOUT_EN
      wd_cnt    <= {TW{1'b0}};
`endif
    end else begin
      case (state)
        IDLE: begin
          // The write is applied first so a same-cycle start sees it.
          if (wr_en) begin
            op_mem[wr_addr] <= wr_data;
            done            <= 1'b0;
          end
          if (start) begin
            done      <= 1'b0;
            err       <= 2'b00;
            busy      <= 1'b1;
            k         <= {KW{1'b0}};
            slice_vld <= 1'b1;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          if (wr_en || start) begin
            err[ERR_BUSY] <= 1'b1;
          end
          // The adder's column counter is free-running, so never gap slices.
          if (k == K_LAST) begin
            slice_vld <= 1'b0;
            state     <= WAIT;
`ifdef SEQ_TIMEOUT_EN
            wd_cnt    <= {TW{1'b0}};
`endif
          end else begin
            k <= k + KW'(1);
          end
        end

        WAIT: begin
          if (wr_en || start) begin
            err[ERR_BUSY] <= 1'b1;
          end
          // A result arriving on the timeout cycle takes priority.
          if (res_vld) begin
            sum   <= res;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
`ifdef SEQ_TIMEOUT_EN
          end else if (wd_cnt == TW'(TO_CYC - 1)) begin
            err[ERR_TO] <= 1'b1;
            done        <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + TW'(1);
          end
`else
          end else begin
            state <= WAIT;
          end
`endif
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          slice_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule
